ps2_key_decoder: RTL and testbench

- Sits between the PS/2 byte receiver and the game's key-judging logic.
- Consumes raw scancode bytes (received_data / received_data_en) and parses Set-2 make, break (F0) and extended (E0) sequences.
- Emits one-cycle make/break events with a clean key code, plus a held-key bitmap for the five game keys.
- Lets the judge compare against a single resolved event instead of tracking F0 state itself.

---
 rtl/ps2_key_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scancode parser: make/break/extended events plus held-key bitmap.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat make events.
module ps2_key_decoder #(
  parameter int          TIMEOUT_CYCLES = 2_500_000,
  parameter logic [7:0]  KEY_SPACE      = 8'h29,
  parameter logic [7:0]  KEY_A          = 8'h1c,
  parameter logic [7:0]  KEY_S          = 8'h1b,
  parameter logic [7:0]  KEY_D          = 8'h23,
  parameter logic [7:0]  KEY_F          = 8'h2b
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic       key_break,
  output logic [4:0] held,
  output logic       seq_timeout
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_e0;
  logic          w_f0;
  logic          w_ign;
  logic          w_err;
  logic          w_data;
  logic          w_make;
  logic          w_break;
  logic          w_ext;
  logic          w_expire;
  logic          w_fire;
  logic [4:0]    w_hit;

  always_comb begin
    w_e0   = 1'b0;
    w_f0   = 1'b0;
    w_ign  = 1'b0;
    w_err  = 1'b0;
    w_data = 1'b0;
    unique case (1'b1)
      (received_data == 8'hE0): w_e0 = 1'b1;
      (received_data == 8'hF0): w_f0 = 1'b1;
      (received_data inside {8'hFA, 8'hAA, 8'hEE, 8'hE1}):
        w_ign = 1'b1;
      (received_data inside {8'h00, 8'hFF}):
        w_err = 1'b1;
      default: w_data = 1'b1;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_make   = 1'b0;
    w_break  = 1'b0;
    w_ext    = 1'b0;
    w_expire = 1'b0;
    if (received_data_en) begin
      if (w_err) begin
        w_next = IDLE;
      end else if (w_data) begin
        w_next = IDLE;
        unique case (r_state)
          IDLE:     w_make = 1'b1;
          GOT_E0: begin
            w_make = 1'b1;
            w_ext  = 1'b1;
          end
          GOT_F0:   w_break = 1'b1;
          GOT_E0F0: begin
            w_break = 1'b1;
            w_ext   = 1'b1;
          end
        endcase
      end else if (w_e0) begin
        unique case (r_state)
          IDLE:    w_next = GOT_E0;
          GOT_F0:  w_next = GOT_E0F0;
          default: w_next = r_state;
        endcase
      end else if (w_f0) begin
        unique case (r_state)
          IDLE:    w_next = GOT_F0;
          GOT_E0:  w_next = GOT_E0F0;
          default: w_next = r_state;
        endcase
      end
    end else if (r_state != IDLE && r_cnt == LAST) begin
      w_next   = IDLE;
      w_expire = 1'b1;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] r_last;

  // Code 00 is never DATA, so a cleared r_last never matches a make.
  assign w_fire = w_make &&
    ({w_ext, received_data} != r_last);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_last <= '0;
    end else if (w_break || w_expire) begin
      r_last <= '0;
    end else if (w_make) begin
      r_last <= {w_ext, received_data};
    end
  end
`else
  assign w_fire = w_make;
`endif

  assign w_hit = {
    received_data == KEY_SPACE,
    received_data == KEY_A,
    received_data == KEY_S,
    received_data == KEY_D,
    received_data == KEY_F
  };

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_make    <= 1'b0;
      key_break   <= 1'b0;
      held        <= 5'b0;
      seq_timeout <= 1'b0;
    end else begin
      r_state     <= w_next;
      key_make    <= w_fire;
      key_break   <= w_break;
      seq_timeout <= w_expire;
      if (received_data_en || r_state == IDLE || w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fire || w_break) begin
        key_code <= received_data;
        key_ext  <= w_ext;
      end
      if (!w_ext && w_make) begin
        held <= held | w_hit;
      end else if (!w_ext && w_break) begin
        held <= held & ~w_hit;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected events are queued
// as bytes are driven and popped when a make/break pulse appears.
module tb_ps2_key_decoder;

  typedef struct packed {
    logic       mk;
    logic       ext;
    logic [7:0] code;
    logic [4:0] held;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       en;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       key_break;
  logic [4:0] held;
  logic       seq_timeout;

  ev_t q[$];
  ev_t e;
  int  n_cmp;
  int  n_bad;
  int  n_to;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .received_data   (data),
    .received_data_en(en),
    .key_code        (key_code),
    .key_ext         (key_ext),
    .key_make        (key_make),
    .key_break       (key_break),
    .held            (held),
    .seq_timeout     (seq_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic mk, input logic ext,
                      input logic [7:0] code,
                      input logic [4:0] hl);
    ev_t x;
    x.mk   = mk;
    x.ext  = ext;
    x.code = code;
    x.held = hl;
    q.push_back(x);
  endtask

  task automatic strobe(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    @(negedge clk);
    en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && seq_timeout) n_to++;
    if (!rst && (key_make || key_break)) begin
      check("excl", 32'(key_make & key_break), 0);
      check("sb_avail", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("ev_make", 32'(key_make), 32'(e.mk));
        check("ev_break", 32'(key_break), 32'(!e.mk));
        check("ev_ext", 32'(key_ext), 32'(e.ext));
        check("ev_code", 32'(key_code), 32'(e.code));
        check("ev_held", 32'(held), 32'(e.held));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_cmp = 0;
    n_bad = 0;
    n_to  = 0;
    rst   = 1'b1;
    data  = 8'h00;
    en    = 1'b0;
    @(negedge clk);
    idle(2);
    check("rst_code", 32'(key_code), 0);
    check("rst_ext", 32'(key_ext), 0);
    check("rst_make", 32'(key_make), 0);
    check("rst_break", 32'(key_break), 0);
    check("rst_held", 32'(held), 0);
    check("rst_to", 32'(seq_timeout), 0);
    rst = 1'b0;
    idle(1);

    // plain make on A
    push(1'b1, 1'b0, 8'h1c, 5'b01000);
    strobe(8'h1c);
    @(negedge clk);
    check("make_drop", 32'(key_make), 0);
    check("code_hold", 32'(key_code), 32'h1c);
    idle(2);

    // break on A, one idle cycle between bytes
    push(1'b0, 1'b0, 8'h1c, 5'b00000);
    strobe(8'hF0);
    idle(1);
    strobe(8'h1c);
    idle(2);

    // extended break then extended make on A code
    push(1'b0, 1'b1, 8'h75, 5'b00000);
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h75);
    idle(2);
    push(1'b1, 1'b1, 8'h1c, 5'b00000);
    strobe(8'hE0);
    strobe(8'h1c);
    idle(1);
    check("ext_held", 32'(held[3]), 0);
    idle(2);

    // dangling F0 times out, next byte is a make
    strobe(8'hF0);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(posedge clk);
      #1;
      if (seq_timeout) k = i;
    end
    check("to_lat", 32'(k), 16);
    check("to_held", 32'(held), 0);
    @(negedge clk);
    push(1'b1, 1'b0, 8'h23, 5'b00010);
    strobe(8'h23);
    idle(2);

    // typematic repeats on S
    push(1'b1, 1'b0, 8'h1b, 5'b00110);
`ifndef PS2_TYPEMATIC_FILTER_EN
    push(1'b1, 1'b0, 8'h1b, 5'b00110);
    push(1'b1, 1'b0, 8'h1b, 5'b00110);
`endif
    for (int i = 0; i < 3; i++) begin
      strobe(8'h1b);
      idle(1);
    end
    push(1'b0, 1'b0, 8'h1b, 5'b00010);
    strobe(8'hF0);
    strobe(8'h1b);
    idle(2);

    // ignore bytes, then space
    strobe(8'hAA);
    strobe(8'hFA);
    push(1'b1, 1'b0, 8'h29, 5'b10010);
    strobe(8'h29);
    idle(2);

    // reset mid E0 sequence
    strobe(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_held", 32'(held), 0);
    check("mid_rst_code", 32'(key_code), 0);
    push(1'b1, 1'b0, 8'h2b, 5'b00001);
    strobe(8'h2b);
    idle(2);

    // back-to-back makes
    push(1'b1, 1'b0, 8'h1c, 5'b01001);
    push(1'b1, 1'b0, 8'h1b, 5'b01101);
    strobe(8'h1c);
    strobe(8'h1b);
    idle(2);

    // error byte aborts E0 prefix
    push(1'b1, 1'b0, 8'h23, 5'b01111);
    strobe(8'hE0);
    strobe(8'hFF);
    strobe(8'h23);
    idle(4);

    check("sb_drain", 32'(q.size()), 0);
    check("to_count", 32'(n_to), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
